ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 153 +++++++++++++++
 tb/tb_ex_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU for opcodes 0-13 and a 32-step iterative
// multiply/divide unit for opcodes 14-15. It stalls the ID/EX register while it iterates.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_num1,
    input  logic [31:0] ex_num2,
    input  logic [3:0]  ex_aluOp,
    input  logic        ex_regWriteEn,
    input  logic [4:0]  ex_regWriteAddr,
    input  logic [31:0] ex_linkAddr,
    input  logic        flush,
    output logic        stall_req,
    output logic        mem_valid,
    output logic        mem_regWriteEn,
    output logic [4:0]  mem_regWriteAddr,
    output logic [31:0] mem_result
);

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
        OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_LINK, OP_MULU, OP_DIVU
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    alu_op_e     op;
    state_e      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        iter_op, start;
    logic [31:0] alu_result;
    logic [31:0] work_a_q, work_b_q, acc_q;
    logic        is_div_q, cap_wen_q;
    logic [4:0]  cap_addr_q;
    logic [32:0] rem_shift, rem_diff;
    logic        div_take;
    logic [31:0] iter_result;

    assign op      = alu_op_e'(ex_aluOp);
    assign iter_op = (op == OP_MULU) || (op == OP_DIVU);
    assign start   = (state_q == IDLE) && ex_valid && iter_op && !flush;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = ex_num1 + ex_num2;
            OP_SUB:  alu_result = ex_num1 - ex_num2;
            OP_AND:  alu_result = ex_num1 & ex_num2;
            OP_OR:   alu_result = ex_num1 | ex_num2;
            OP_XOR:  alu_result = ex_num1 ^ ex_num2;
            OP_NOR:  alu_result = ~(ex_num1 | ex_num2);
            OP_SLT:  alu_result = {31'b0, $signed(ex_num1) < $signed(ex_num2)};
            OP_SLTU: alu_result = {31'b0, ex_num1 < ex_num2};
            OP_SLL:  alu_result = ex_num1 << ex_num2[4:0];
            OP_SRL:  alu_result = ex_num1 >> ex_num2[4:0];
            OP_SRA:  alu_result = $signed(ex_num1) >>> ex_num2[4:0];
            OP_LUI:  alu_result = ex_num2 << 16;
            OP_LINK: alu_result = ex_linkAddr;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid && iter_op) begin
                    stall_req = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (cnt_q == 5'd31) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A redirect or reset kills the operation and releases upstream at once.
        if (flush) begin
            state_d   = IDLE;
            stall_req = 1'b0;
        end
        if (rst) stall_req = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (flush || start)      cnt_q <= '0;
            else if (state_q == BUSY) cnt_q <= cnt_q + 5'd1;
        end
    end

    // Restoring division: shift in one dividend bit, subtract the divisor if it fits.
    assign rem_shift   = {acc_q, work_a_q[31]};
    assign rem_diff    = rem_shift - {1'b0, work_b_q};
    assign div_take    = rem_shift >= {1'b0, work_b_q};
    assign iter_result = is_div_q ? work_a_q : acc_q;

    // NOTE: the working registers are always loaded on start before being used, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            work_a_q   <= ex_num1;
            work_b_q   <= ex_num2;
            acc_q      <= '0;
            is_div_q   <= (op == OP_DIVU);
            cap_wen_q  <= ex_regWriteEn && (ex_regWriteAddr != 5'd0);
            cap_addr_q <= ex_regWriteAddr;
        end else if (state_q == BUSY && !flush) begin
            if (is_div_q) begin
                work_a_q <= {work_a_q[30:0], div_take};
                acc_q    <= div_take ? rem_diff[31:0] : rem_shift[31:0];
            end else begin
                if (work_b_q[0]) acc_q <= acc_q + work_a_q;
                work_a_q <= work_a_q << 1;
                work_b_q <= work_b_q >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid        <= 1'b0;
            mem_regWriteEn   <= 1'b0;
            mem_regWriteAddr <= '0;
            mem_result       <= '0;
        end else if (flush || stall_req) begin
            mem_valid      <= 1'b0;
            mem_regWriteEn <= 1'b0;
        end else if (state_q == DONE) begin
            mem_valid        <= 1'b1;
            mem_regWriteEn   <= cap_wen_q;
            mem_regWriteAddr <= cap_addr_q;
            mem_result       <= iter_result;
        end else begin
            mem_valid      <= ex_valid;
            mem_regWriteEn <= ex_valid && ex_regWriteEn && (ex_regWriteAddr != 5'd0);
            if (ex_valid) begin
                mem_regWriteAddr <= ex_regWriteAddr;
                mem_result       <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomised scoreboard bench for ex_stage: a driver issues instructions and pushes expected
// results from an arithmetic reference model; a monitor pops and compares each mem_valid pulse.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_num1, ex_num2, ex_linkAddr;
    logic [3:0]  ex_aluOp;
    logic        ex_regWriteEn;
    logic [4:0]  ex_regWriteAddr;
    logic        flush;
    logic        stall_req, mem_valid, mem_regWriteEn;
    logic [4:0]  mem_regWriteAddr;
    logic [31:0] mem_result;

    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] result;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [31:0] last_result = '0;
    logic [4:0]  last_addr = '0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_num1(ex_num1), .ex_num2(ex_num2),
        .ex_aluOp(ex_aluOp), .ex_regWriteEn(ex_regWriteEn), .ex_regWriteAddr(ex_regWriteAddr),
        .ex_linkAddr(ex_linkAddr), .flush(flush), .stall_req(stall_req), .mem_valid(mem_valid),
        .mem_regWriteEn(mem_regWriteEn), .mem_regWriteAddr(mem_regWriteAddr), .mem_result(mem_result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b, link);
        logic [63:0] prod;
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return ~(a | b);
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return a << sh;
            4'd10: return a >> sh;
            4'd11: return 32'($signed(a) >>> sh);
            4'd12: return b * 32'd65536;
            4'd13: return link;
            4'd14: begin
                prod = {32'd0, a} * {32'd0, b};
                return prod[31:0];
            end
            4'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: every valid output must match the oldest outstanding expectation;
    // every bubble must keep the last delivered address and result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got result 0x%08h, expected no output", mem_result);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", mem_result, mon_e.result);
                    check("wen", 32'(mem_regWriteEn), 32'(mon_e.wen));
                    check("addr", 32'(mem_regWriteAddr), 32'(mon_e.addr));
                    last_result = mon_e.result;
                    last_addr   = mon_e.addr;
                end
            end else begin
                check("bubble_wen", 32'(mem_regWriteEn), 32'd0);
                check("hold_result", mem_result, last_result);
                check("hold_addr", 32'(mem_regWriteAddr), 32'(last_addr));
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input logic wen,
                         input logic [4:0] addr, input logic [31:0] link, input int exp_stall);
        int stalls;
        stalls          = 0;
        ex_valid        = 1'b1;
        ex_aluOp        = op;
        ex_num1         = a;
        ex_num2         = b;
        ex_regWriteEn   = wen;
        ex_regWriteAddr = addr;
        ex_linkAddr     = link;
        #1;
        while (stall_req && stalls <= 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        exp_q.push_back('{wen: wen && (addr != 5'd0), addr: addr, result: ref_alu(op, a, b, link)});
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        check("latency_valid", 32'(mem_valid), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ex_valid        = 1'b0;
            ex_aluOp        = 4'($urandom_range(0, 15));
            ex_num1         = $urandom;
            ex_num2         = $urandom;
            ex_regWriteEn   = 1'b1;
            ex_regWriteAddr = 5'($urandom_range(1, 31));
            #1;
            check("idle_no_stall", 32'(stall_req), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic start_div_and_wait(input int n);
        ex_valid        = 1'b1;
        ex_aluOp        = 4'd15;
        ex_num1         = 32'd1000;
        ex_num2         = 32'd3;
        ex_regWriteEn   = 1'b1;
        ex_regWriteAddr = 5'd9;
        repeat (n) @(negedge clk);
        #1;
        check("abort_pre_stall", 32'(stall_req), 32'd1);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b;
        rst             = 1'b1;
        flush           = 1'b0;
        ex_valid        = 1'b1;
        ex_aluOp        = 4'd14;
        ex_num1         = 32'd3;
        ex_num2         = 32'd5;
        ex_regWriteEn   = 1'b1;
        ex_regWriteAddr = 5'd7;
        ex_linkAddr     = '0;
        #1;
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_wen", 32'(mem_regWriteEn), 32'd0);
        check("rst_addr", 32'(mem_regWriteAddr), 32'd0);
        check("rst_result", mem_result, 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_stall_held", 32'(stall_req), 32'd0);
        ex_valid = 1'b0;
        rst      = 1'b0;
        mon_en   = 1'b1;
        @(negedge clk);

        // Directed cases from the requirements.
        issue(4'd1,  32'h7FFF_FFFF, 32'd1, 1'b1, 5'd5, 32'd0, 0);
        issue(4'd7,  32'hFFFF_FFFF, 32'd1, 1'b1, 5'd6, 32'd0, 0);
        issue(4'd8,  32'hFFFF_FFFF, 32'd1, 1'b1, 5'd6, 32'd0, 0);
        issue(4'd11, 32'h8000_0000, 32'd4, 1'b1, 5'd8, 32'd0, 0);
        issue(4'd14, 32'h0001_0001, 32'h0001_0001, 1'b1, 5'd3, 32'd0, 33);
        idle(2);
        issue(4'd15, 32'd100, 32'd7, 1'b1, 5'd4, 32'd0, 33);
        issue(4'd15, 32'd5, 32'd0, 1'b1, 5'd4, 32'd0, 33);
        issue(4'd1,  32'd3, 32'd4, 1'b1, 5'd0, 32'd0, 0);
        issue(4'd13, 32'd0, 32'd0, 1'b1, 5'd31, 32'hDEAD_BEEC, 0);
        issue(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd2, 32'd0, 33);

        // Flush in the middle of a divide: stall drops at once, nothing is ever produced.
        start_div_and_wait(10);
        flush = 1'b1;
        #1;
        check("flush_stall_comb", 32'(stall_req), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        ex_valid = 1'b0;
        #1;
        check("flush_bubble", 32'(mem_valid), 32'd0);
        check("flush_stall_after", 32'(stall_req), 32'd0);
        idle(40);

        // Reset in the middle of a divide: outputs clear without a clock edge.
        issue(4'd1, 32'h0000_1000, 32'h0000_0234, 1'b1, 5'd12, 32'd0, 0);
        start_div_and_wait(10);
        rst         = 1'b1;
        last_result = '0;
        last_addr   = '0;
        #1;
        check("arst_valid", 32'(mem_valid), 32'd0);
        check("arst_wen", 32'(mem_regWriteEn), 32'd0);
        check("arst_addr", 32'(mem_regWriteAddr), 32'd0);
        check("arst_result", mem_result, 32'd0);
        check("arst_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst      = 1'b0;
        idle(40);
        issue(4'd1, 32'd10, 32'd20, 1'b1, 5'd1, 32'd0, 0);

        // Randomised instruction stream with occasional bubbles.
        for (int i = 0; i < 60; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 300));
                default: r_b = $urandom;
            endcase
            issue(r_op, r_a, r_b, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom, (r_op >= 4'd14) ? 33 : 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
